// File: rtl/mem_responder_if.sv
// Load/store port between the core (master) and the memory responder (slave).
// Request channel : req_valid/req_ready handshake carrying wen, addr, size, wdata, wmask.
// Response channel: resp_valid/resp_ready handshake carrying rdata and err.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM answering one load/store request at a time.
// Stores are byte-masked, loads are sized and zero-extended; the result appears
// LATENCY cycles after the request is accepted and is held until taken.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; drops any pending request, RAM is kept
//   bus    slave side of mem_responder_if (request and response channels)
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Latched request, used while waiting out the latency
  logic        wen_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic        accept;
  logic        exec;
  logic        ram_we;

  // Access operands: live bus inputs when executing on the accept edge
  // (LATENCY == 1), otherwise the latched copy.
  logic        x_wen;
  logic [31:0] x_addr;
  logic [1:0]  x_size;
  logic [31:0] x_wdata;
  logic [3:0]  x_wmask;

  logic [31:0] off;
  logic [1:0]  lane;
  logic [IDX_W-1:0] idx;
  logic        acc_err;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [3:0]  eff_mask;
  logic [31:0] eff_data;

  assign accept        = bus.req_valid && (state_q == IDLE) && !reset;
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    if (state_q == IDLE) begin
      x_wen   = bus.req_wen;
      x_addr  = bus.req_addr;
      x_size  = bus.req_size;
      x_wdata = bus.req_wdata;
      x_wmask = bus.req_wmask;
    end else begin
      x_wen   = wen_q;
      x_addr  = addr_q;
      x_size  = size_q;
      x_wdata = wdata_q;
      x_wmask = wmask_q;
    end
  end

  // Address decode and fault detection; 32-bit unsigned wrap below BASE_ADDR
  // is caught by the explicit less-than test.
  always_comb begin
    off     = x_addr - BASE_ADDR;
    lane    = x_addr[1:0];
    idx     = off[IDX_W+1:2];
    acc_err = (x_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS)) ||
              (x_size == 2'd3) ||
              ((x_size == 2'd1) && lane[0]) ||
              ((x_size == 2'd2) && (lane != 2'd0));
    shifted = ram_q[idx] >> {lane, 3'b000};
    case (x_size)
      2'd0:    load_val = shifted & 32'h0000_00FF;
      2'd1:    load_val = shifted & 32'h0000_FFFF;
      default: load_val = shifted;
    endcase
    // Bytes shifted past lane 3 fall off the 4-bit / 32-bit results.
    eff_mask = x_wmask << lane;
    eff_data = x_wdata << {lane, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            exec    = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          exec    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (exec) begin
      err_d   = acc_err;
      rdata_d = (acc_err || x_wen) ? 32'd0 : load_val;
    end
  end

  assign ram_we = exec && !reset && !acc_err && x_wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
    if (accept) begin
      wen_q   <= bus.req_wen;
      addr_q  <= bus.req_addr;
      size_q  <= bus.req_size;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_mask[b]) ram_q[idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Three responders: a (LATENCY 2), b (LATENCY 3), c (LATENCY 1)
  mem_responder_if ifa ();
  mem_responder_if ifb ();
  mem_responder_if ifc ();
  mem_responder #(.LATENCY(2)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_responder #(.LATENCY(3)) u_b (.clk(clk), .reset(reset), .bus(ifb));
  mem_responder #(.LATENCY(1)) u_c (.clk(clk), .reset(reset), .bus(ifc));

  int          t_sel = 0;
  logic        t_valid = 1'b0;
  logic        t_wen = 1'b0;
  logic [31:0] t_addr = '0;
  logic [1:0]  t_size = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_wmask = '0;
  logic        t_rready = 1'b1;

  assign ifa.req_valid = t_valid && (t_sel == 0);
  assign ifb.req_valid = t_valid && (t_sel == 1);
  assign ifc.req_valid = t_valid && (t_sel == 2);
  assign {ifa.req_wen, ifb.req_wen, ifc.req_wen} = {3{t_wen}};
  assign {ifa.req_addr, ifb.req_addr, ifc.req_addr} = {3{t_addr}};
  assign {ifa.req_size, ifb.req_size, ifc.req_size} = {3{t_size}};
  assign {ifa.req_wdata, ifb.req_wdata, ifc.req_wdata} = {3{t_wdata}};
  assign {ifa.req_wmask, ifb.req_wmask, ifc.req_wmask} = {3{t_wmask}};
  assign {ifa.resp_ready, ifb.resp_ready, ifc.resp_ready} = {3{t_rready}};

  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  always_comb begin
    m_ready = ifa.req_ready; m_valid = ifa.resp_valid; m_rdata = ifa.resp_rdata; m_err = ifa.resp_err;
    if (t_sel == 1) begin
      m_ready = ifb.req_ready; m_valid = ifb.resp_valid; m_rdata = ifb.resp_rdata; m_err = ifb.resp_err;
    end else if (t_sel == 2) begin
      m_ready = ifc.req_ready; m_valid = ifc.resp_valid; m_rdata = ifc.resp_rdata; m_err = ifc.resp_err;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every new response, pop the expected entry and compare.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid && !prev) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", m_rdata, e.rdata);
          check("resp_err", {31'd0, m_err}, {31'd0, e.err});
          check("resp_latency", cyc - acc_cyc, e.lat);
        end
      end
      prev = m_valid;
    end
  end

  task automatic issue(input int s, input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input logic [3:0] wm, input logic push,
                       input logic [31:0] er, input logic ee, input int el);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    t_sel = s; t_wen = wen; t_addr = addr; t_size = size; t_wdata = wd; t_wmask = wm; t_valid = 1'b1;
    #1;
    while (!m_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!m_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      t_valid = 1'b0;
      return;
    end
    e.rdata = er; e.err = ee; e.lat = el;
    if (push) sb.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
    t_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk); n++;
    end
    if (!m_valid) check("resp_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic xfer(input int s, input logic wen, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wd, input logic [3:0] wm,
                      input logic [31:0] er, input logic ee, input int el);
    issue(s, wen, addr, size, wd, wm, 1'b1, er, ee, el);
    wait_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, ifa.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, ifa.resp_valid}, 32'd0);
    check("rst_resp_rdata", ifa.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, ifa.resp_err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, ifa.req_ready}, 32'd1);

    // 1: word store then word load
    xfer(0, 1, 32'h8000_0010, 2, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 2);
    xfer(0, 0, 32'h8000_0010, 2, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    // 2: byte store into lane 3
    xfer(0, 1, 32'h8000_0013, 0, 32'h0000_00AA, 4'b0001, 32'h0, 0, 2);
    xfer(0, 0, 32'h8000_0010, 2, 32'h0, 4'h0, 32'hAAAD_BEEF, 0, 2);
    xfer(0, 0, 32'h8000_0013, 0, 32'h0, 4'h0, 32'h0000_00AA, 0, 2);
    // 3: halves, misalignment, reserved size
    xfer(0, 0, 32'h8000_0012, 1, 32'h0, 4'h0, 32'h0000_AAAD, 0, 2);
    xfer(0, 0, 32'h8000_0011, 1, 32'h0, 4'h0, 32'h0, 1, 2);
    xfer(0, 1, 32'h8000_0000, 2, 32'h0102_0304, 4'hF, 32'h0, 0, 2);
    xfer(0, 1, 32'h8000_0002, 2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 2);
    xfer(0, 0, 32'h8000_0000, 2, 32'h0, 4'h0, 32'h0102_0304, 0, 2);
    xfer(0, 0, 32'h8000_0010, 3, 32'h0, 4'h0, 32'h0, 1, 2);
    // 4: address window edges
    xfer(0, 0, 32'h7FFF_FFFC, 2, 32'h0, 4'h0, 32'h0, 1, 2);
    xfer(0, 0, 32'h8000_1000, 2, 32'h0, 4'h0, 32'h0, 1, 2);
    xfer(0, 1, 32'h8000_0FFC, 2, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 2);
    xfer(0, 0, 32'h8000_0FFC, 2, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 2);

    // 5: response back-pressure
    t_rready = 1'b0;
    issue(0, 0, 32'h8000_0010, 2, 32'h0, 4'h0, 1'b1, 32'hAAAD_BEEF, 0, 2);
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk); n++;
    end
    check("stall_resp_seen", {31'd0, m_valid}, 32'd1);
    t_wen = 1'b1; t_addr = 32'h8000_0010; t_size = 2; t_wdata = 32'h1111_1111; t_wmask = 4'hF;
    t_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, m_valid}, 32'd1);
      check("stall_rdata", m_rdata, 32'hAAAD_BEEF);
      check("stall_req_ready", {31'd0, m_ready}, 32'd0);
    end
    t_valid = 1'b0;
    t_rready = 1'b1;
    @(negedge clk);
    check("post_hs_req_ready", {31'd0, m_ready}, 32'd1);
    check("post_hs_valid", {31'd0, m_valid}, 32'd0);
    xfer(0, 0, 32'h8000_0010, 2, 32'h0, 4'h0, 32'hAAAD_BEEF, 0, 2);

    // 6: reset while a store is pending (LATENCY 3), then LATENCY 1
    xfer(1, 1, 32'h8000_0020, 2, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 3);
    issue(1, 1, 32'h8000_0020, 2, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ifb.resp_valid) seen = 1'b1;
    end
    check("reset_drops_resp", {31'd0, seen}, 32'd0);
    xfer(1, 0, 32'h8000_0020, 2, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 3);
    xfer(2, 1, 32'h8000_0000, 2, 32'h55AA_55AA, 4'hF, 32'h0, 0, 1);
    xfer(2, 0, 32'h8000_0000, 2, 32'h0, 4'h0, 32'h55AA_55AA, 0, 1);
    xfer(2, 0, 32'h8000_0002, 1, 32'h0, 4'h0, 32'h0000_55AA, 0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
